// File: rtl/rv_ctrl_pkg.sv
// Shared types for the multicycle RV32I controller: opcodes, FSM states,
// ALU operations, datapath select encodings and instruction classes.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_t;

    typedef enum logic [3:0] {
        C_R      = 4'd0,
        C_I      = 4'd1,
        C_LOAD   = 4'd2,
        C_STORE  = 4'd3,
        C_BRANCH = 4'd4,
        C_JAL    = 4'd5,
        C_JALR   = 4'd6,
        C_LUI    = 4'd7,
        C_AUIPC  = 4'd8,
        C_ILL    = 4'd9
    } iclass_t;

    function automatic iclass_t classify(input logic [6:0] op);
        iclass_t c;
        c = C_ILL;
        unique case (1'b1)
            op == OP_R:      c = C_R;
            op == OP_I:      c = C_I;
            op == OP_LOAD:   c = C_LOAD;
            op == OP_STORE:  c = C_STORE;
            op == OP_BRANCH: c = C_BRANCH;
            op == OP_JAL:    c = C_JAL;
            op == OP_JALR:   c = C_JALR;
            op == OP_LUI:    c = C_LUI;
            op == OP_AUIPC:  c = C_AUIPC;
            default:         c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational mapping from instruction class and func3/func7[5]
// to the ALU operation used in the execute state.
module alu_op_decode
    import rv_ctrl_pkg::*;
(
    input  iclass_t     i_cls,
    input  logic [2:0]  i_func3,
    input  logic        i_func7_5,
    output alu_op_t     o_alu_op
);

    logic w_arith;
    assign w_arith = (i_cls == C_R) || (i_cls == C_I);

    always_comb begin
        o_alu_op = ALU_ADD;
        unique case (1'b1)
            w_arith: begin
                case (i_func3)
                    // Immediate forms have no SUBI: func7 only selects SRA
                    3'b000: o_alu_op = (i_cls == C_R && i_func7_5)
                                       ? ALU_SUB : ALU_ADD;
                    3'b001: o_alu_op = ALU_SLL;
                    3'b010: o_alu_op = ALU_SLT;
                    3'b011: o_alu_op = ALU_SLTU;
                    3'b100: o_alu_op = ALU_XOR;
                    3'b101: o_alu_op = i_func7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: o_alu_op = ALU_OR;
                    default: o_alu_op = ALU_AND;
                endcase
            end
            i_cls == C_BRANCH: o_alu_op = ALU_SUB;
            i_cls == C_LUI:    o_alu_op = ALU_PASS_B;
            default:           o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory timeout trap.
// Optional RETIRE_CNT_EN adds a 32-bit retired-instruction counter port.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [3:0]  alu_op,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    localparam int CW = (TO_W > 0) ? TO_W : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          r_state;
    state_t          w_next;
    iclass_t         r_cls;
    iclass_t         w_cls;
    logic [2:0]      r_func3;
    logic            r_f7b5;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_illegal;
    logic            r_bus_err;
    logic            w_timeout;
    logic            w_set_ill;
    logic            w_set_berr;
    alu_op_t         w_dec_op;
    logic            w_unused_f7;

    assign w_cls       = classify(opcode);
    assign w_timeout   = (MEM_TIMEOUT > 0) && (r_wait_cnt == TO_LAST);
    assign w_unused_f7 = ^{func7[6], func7[4:0]};
    assign state_o     = r_state;
    assign illegal     = r_illegal;
    assign bus_err     = r_bus_err;

    alu_op_decode u_alu_dec (
        .i_cls     (r_cls),
        .i_func3   (r_func3),
        .i_func7_5 (r_f7b5),
        .o_alu_op  (w_dec_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_cls      <= C_ILL;
            r_func3    <= '0;
            r_f7b5     <= 1'b0;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | w_set_ill;
            r_bus_err <= r_bus_err | w_set_berr;
            if (r_state == S_DECODE) begin
                r_cls   <= w_cls;
                r_func3 <= func3;
                r_f7b5  <= func7[5];
            end
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        rf_we      = 1'b0;
        alu_op     = ALU_ADD;
        alu_a_sel  = 1'b0;
        alu_b_sel  = B_RS2;
        wb_sel     = WB_ALU;
        w_set_ill  = 1'b0;
        w_set_berr = 1'b0;
        unique case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_set_berr = 1'b1;
                    w_next     = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_cls == C_ILL) begin
                    w_set_ill = 1'b1;
                    w_next    = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = w_dec_op;
                w_next = S_WB;
                case (r_cls)
                    C_I, C_LUI: alu_b_sel = B_IMM;
                    C_LOAD, C_STORE: begin
                        alu_b_sel = B_IMM;
                        w_next    = S_MEM;
                    end
                    C_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = B_IMM;
                    end
                    C_JAL: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = B_IMM;
                        pc_we     = 1'b1;
                        pc_sel    = PC_TARGET;
                    end
                    C_JALR: begin
                        alu_b_sel = B_IMM;
                        pc_we     = 1'b1;
                        pc_sel    = PC_JALR;
                    end
                    C_BRANCH: begin
                        w_next = S_FETCH;
                        if (branch_taken) begin
                            pc_we  = 1'b1;
                            pc_sel = PC_TARGET;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_cls == C_STORE);
                if (dmem_ready) begin
                    w_next = (r_cls == C_STORE) ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_set_berr = 1'b1;
                    w_next     = S_TRAP;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                w_next = S_FETCH;
                if (r_cls == C_LOAD)
                    wb_sel = WB_LOAD;
                else if (r_cls == C_JAL || r_cls == C_JALR)
                    wb_sel = WB_PC4;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_RESET;
        endcase
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] r_retire;
    logic        w_retire;

    // Completion points: WB exit, store MEM exit, branch EXEC exit
    assign w_retire = (r_state == S_WB)
                    || (r_state == S_MEM && r_cls == C_STORE && dmem_ready)
                    || (r_state == S_EXEC && r_cls == C_BRANCH);
    assign retire_cnt = r_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_retire <= '0;
        else if (w_retire)
            r_retire <= r_retire + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Builds with or without RETIRE_CNT_EN.
module tb_multicycle_controller;
    import rv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic [1:0]  pc_sel, alu_b_sel, wb_sel;
    logic [3:0]  alu_op;
    logic        alu_a_sel, illegal, bus_err;
    logic [2:0]  state_o;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wire [21:0] obs = {state_o, imem_req, dmem_req, dmem_we, ir_we, pc_we,
                       pc_sel, rf_we, alu_op, alu_a_sel, alu_b_sel, wb_sel,
                       illegal, bus_err};

    multicycle_controller #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
        .func7(func7), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
        .state_o(state_o)
`ifdef RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] pk(
        state_t s, logic ireq, logic dreq, logic dwe, logic irwe,
        logic pcwe, logic [1:0] pcs, logic rfwe, alu_op_t op,
        logic as, logic [1:0] bs, logic [1:0] wb, logic ill, logic be);
        return {s, ireq, dreq, dwe, irwe, pcwe, pcs, rfwe, op,
                as, bs, wb, ill, be};
    endfunction

    logic [21:0] e_fe, e_fwait, e_de, e_wb0, e_wb1, e_wb2, e_mld, e_zero;

    task automatic cyc(input logic ir, input logic dr, input logic bt);
        @(negedge clk);
        imem_ready   = ir;
        dmem_ready   = dr;
        branch_taken = bt;
        #1;
    endtask

    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== e_zero) begin
            errors++;
            $display("FAIL %s async: got %h want %h", name, obs, e_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = '0; func3 = '0; func7 = '0;
        branch_taken = 0; imem_ready = 0; dmem_ready = 0;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== e_zero) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, e_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== e_zero) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, e_zero);
        end
    endtask

    task automatic test_alu_instr(input string name, input logic [6:0] opc,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [21:0] e_ex,
                                  input logic [21:0] e_w);
        logic [21:0] e [4];
        e[0] = e_fe; e[1] = e_de; e[2] = e_ex; e[3] = e_w;
        opcode = opc; func3 = f3; func7 = f7;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            // class is latched in DECODE: later opcode changes are ignored
            if (i == 2) opcode = 7'h7F;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL %s cyc%0d: got %h want %h",
                         name, i, obs, e[i]);
            end
        end
    endtask

    task automatic test_load_wait();
        logic [21:0] e [8];
        logic        dr [8];
        e[0] = e_fe; e[1] = e_de;
        e[2] = pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 1, 0, 0, 0);
        for (int i = 3; i < 7; i++) e[i] = e_mld;
        e[7] = e_wb1;
        dr = '{1, 1, 1, 0, 0, 0, 1, 0};
        opcode = OP_LOAD; func3 = 3'b010; func7 = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, dr[i], 1'b0);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL load_wait cyc%0d: got %h want %h",
                         i, obs, e[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [21:0] e [4];
        e[0] = e_fe; e[1] = e_de;
        e[2] = pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 1, 0, 0, 0);
        e[3] = pk(S_MEM, 0, 1, 1, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        opcode = OP_STORE; func3 = 3'b010; func7 = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL store cyc%0d: got %h want %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_branch(input logic bt);
        logic [21:0] e [3];
        e[0] = e_fe; e[1] = e_de;
        e[2] = bt ? pk(S_EXEC, 0, 0, 0, 0, 1, 1, 0, ALU_SUB, 0, 0, 0, 0, 0)
                  : pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_SUB, 0, 0, 0, 0, 0);
        opcode = OP_BRANCH; func3 = 3'b000; func7 = '0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, bt);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL branch_bt%0d cyc%0d: got %h want %h",
                         bt, i, obs, e[i]);
            end
        end
    endtask

    task automatic test_fetch_timeout_edge();
        logic [21:0] e;
        opcode = OP_R; func3 = '0; func7 = '0;
        for (int i = 0; i < 19; i++) begin
            cyc(i >= 15, 1'b0, 1'b0);
            e = (i < 15) ? e_fwait : (i == 15) ? e_fe : (i == 16) ? e_de
              : (i == 17)
              ? pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0)
              : e_wb0;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL fetch_ready_last cyc%0d: got %h want %h",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_fetch_timeout();
        logic [21:0] e;
        opcode = OP_R;
        for (int i = 0; i < 20; i++) begin
            cyc(i >= 16, 1'b0, 1'b0);
            e = (i < 16) ? e_fwait
              : pk(S_TRAP, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL fetch_timeout cyc%0d: got %h want %h",
                         i, obs, e);
            end
        end
        reset_pulse("fetch_timeout_clear");
    endtask

    task automatic test_mem_timeout();
        logic [21:0] e;
        opcode = OP_LOAD; func3 = 3'b010;
        for (int i = 0; i < 21; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            e = (i == 0) ? e_fe : (i == 1) ? e_de
              : (i == 2)
              ? pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 1, 0, 0, 0)
              : (i < 19) ? e_mld
              : pk(S_TRAP, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mem_timeout cyc%0d: got %h want %h",
                         i, obs, e);
            end
        end
        reset_pulse("mem_timeout_clear");
    endtask

    task automatic test_illegal();
        logic [21:0] e;
        opcode = 7'h7F; func3 = '0; func7 = '0;
        for (int i = 0; i < 22; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            e = (i == 0) ? e_fe : (i == 1) ? e_de
              : pk(S_TRAP, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 1, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal cyc%0d: got %h want %h", i, obs, e);
            end
        end
        reset_pulse("illegal_clear");
    endtask

    task automatic test_reset_mid();
        opcode = OP_LOAD; func3 = 3'b010;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== e_mld) begin
            errors++;
            $display("FAIL reset_mid_inmem: got %h want %h", obs, e_mld);
        end
        reset_pulse("reset_mid");
        checks++;
        if (obs !== e_zero) begin
            errors++;
            $display("FAIL reset_mid_release: got %h want %h", obs, e_zero);
        end
    endtask

    task automatic test_retire();
`ifdef RETIRE_CNT_EN
        reset_pulse("retire_reset");
        checks++;
        if (retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL retire_reset: got %0d want 0", retire_cnt);
        end
        for (int n = 0; n < 10; n++)
            test_alu_instr("retire_add", OP_R, 3'b000, 7'h00,
                pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0),
                e_wb0);
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (retire_cnt !== 32'd10) begin
            errors++;
            $display("FAIL retire_10: got %0d want 10", retire_cnt);
        end
`endif
    endtask

    initial begin
        e_zero  = '0;
        e_fe    = pk(S_FETCH, 1, 0, 0, 1, 1, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        e_fwait = pk(S_FETCH, 1, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        e_de    = pk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        e_wb0   = pk(S_WB, 0, 0, 0, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0, 0);
        e_wb1   = pk(S_WB, 0, 0, 0, 0, 0, 0, 1, ALU_ADD, 0, 0, 1, 0, 0);
        e_wb2   = pk(S_WB, 0, 0, 0, 0, 0, 0, 1, ALU_ADD, 0, 0, 2, 0, 0);
        e_mld   = pk(S_MEM, 0, 1, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);

        test_reset();
        test_alu_instr("add", OP_R, 3'b000, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0), e_wb0);
        test_alu_instr("sub", OP_R, 3'b000, 7'h20,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_SUB, 0, 0, 0, 0, 0), e_wb0);
        test_alu_instr("sra", OP_R, 3'b101, 7'h20,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_SRA, 0, 0, 0, 0, 0), e_wb0);
        test_alu_instr("sltu", OP_R, 3'b011, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_SLTU, 0, 0, 0, 0, 0), e_wb0);
        test_alu_instr("addi_f7", OP_I, 3'b000, 7'h20,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 1, 0, 0, 0), e_wb0);
        test_alu_instr("srai", OP_I, 3'b101, 7'h20,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_SRA, 0, 1, 0, 0, 0), e_wb0);
        test_alu_instr("xori", OP_I, 3'b100, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_XOR, 0, 1, 0, 0, 0), e_wb0);
        test_alu_instr("lui", OP_LUI, 3'b000, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_PASS_B, 0, 1, 0, 0, 0),
            e_wb0);
        test_alu_instr("auipc", OP_AUIPC, 3'b000, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 1, 1, 0, 0, 0), e_wb0);
        test_alu_instr("jal", OP_JAL, 3'b000, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 1, 1, 0, ALU_ADD, 1, 1, 0, 0, 0), e_wb2);
        test_alu_instr("jalr", OP_JALR, 3'b000, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 1, 2, 0, ALU_ADD, 0, 1, 0, 0, 0), e_wb2);
        test_load_wait();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_fetch_timeout_edge();
        test_fetch_timeout();
        test_mem_timeout();
        test_illegal();
        test_reset_mid();
        test_alu_instr("after_reset", OP_R, 3'b111, 7'h00,
            pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ALU_AND, 0, 0, 0, 0, 0), e_wb0);
        test_retire();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
